// File: rtl/clk_div_ctrl.sv
// Runtime-programmable even-ratio clock divider for the 1-bit ADC front end.
// New ratios are applied only at a falling edge of clk_out, so no runt pulses are produced.
module clk_div_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rstn,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] active_div,
  output logic             busy
);

  typedef enum logic [1:0] {STOPPED, RUN, PENDING} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] last;
  logic             cfg_ok;
  logic             accept;
  logic             load_ok;
  logic             toggle;

  assign half      = active_div >> 1;
  assign last      = half - CNT_W'(1);
  assign toggle    = (cnt == last);
  assign cfg_ok    = !cfg_div[0] && (cfg_div >= CNT_W'(2));
  assign cfg_ready = (state != PENDING);
  assign accept    = cfg_valid && cfg_ready;
  assign load_ok   = accept && cfg_ok;
  assign busy      = (state != STOPPED);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state      <= STOPPED;
      cnt        <= '0;
      pend_div   <= CNT_W'(DEFAULT_DIV);
      active_div <= CNT_W'(DEFAULT_DIV);
      clk_out    <= 1'b0;
      tick_rise  <= 1'b0;
      tick_fall  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err   <= accept && !cfg_ok;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;

      case (state)
        STOPPED: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (load_ok) active_div <= cfg_div;
          if (enable) state <= RUN;
        end

        RUN: begin
          if (!enable && !clk_out) begin
            cnt   <= '0;
            state <= STOPPED;
            if (load_ok) active_div <= cfg_div;
          end else if (toggle) begin
            cnt       <= '0;
            clk_out   <= !clk_out;
            tick_rise <= !clk_out;
            tick_fall <= clk_out;
            // The high phase ends on this edge, so a ratio arriving now can take over directly.
            if (clk_out) begin
              if (load_ok) active_div <= cfg_div;
              state <= enable ? RUN : STOPPED;
            end else if (load_ok) begin
              pend_div <= cfg_div;
              state    <= PENDING;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (load_ok) begin
              pend_div <= cfg_div;
              state    <= PENDING;
            end
          end
        end

        PENDING: begin
          if (toggle) begin
            cnt       <= '0;
            clk_out   <= !clk_out;
            tick_rise <= !clk_out;
            tick_fall <= clk_out;
            if (clk_out) begin
              active_div <= pend_div;
              state      <= enable ? RUN : STOPPED;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= STOPPED;
      endcase
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable controller around the even-ratio clock divider used by the 1-bit ADC front end. It owns the divide counter and `clk_out` register, accepts new divide ratios over a valid/ready handshake, and applies them only at a falling-edge boundary so `clk_out` never emits a runt pulse. It also gates the divided clock on and off cleanly and emits single-cycle rise/fall ticks for downstream logic in the `clk_in` domain (sampler, decimator enables).

## Interface
- `CNT_W`, 16: width of divide ratio and internal counter.
- `DEFAULT_DIV`, 4: ratio loaded at reset; must be even and at least 2.

Ports:
- `clk_in`  in  1  sole clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; high = divided clock runs.
- `cfg_div`  in  CNT_W  requested divide ratio, full period in `clk_in` cycles.
- `cfg_valid`  in  1  `cfg_div` is valid this cycle.
- `cfg_ready`  out  1  controller can accept a configuration.
- `cfg_err`  out  1  one-cycle pulse: accepted `cfg_div` was rejected (odd or below 2).
- `clk_out`  out  1  divided clock, registered, 50% duty.
- `tick_rise`  out  1  one-cycle pulse in the first cycle `clk_out` is 1.
- `tick_fall`  out  1  one-cycle pulse in the first cycle `clk_out` is 0 after a high phase.
- `active_div`  out  CNT_W  ratio currently in effect.
- `busy`  out  1  high in RUN and PENDING.

## Operation
- `half = active_div >> 1`. The counter runs 0..half-1. At count==half-1: counter goes to 0 and `clk_out` toggles. Otherwise the counter increments.
- **STOPPED**
  - Counter is 0 and `clk_out` is 0.
  - `enable`=1 -> RUN.
  - A valid config accepted here loads into `active_div` at the next edge.
- **RUN**
  - Counter and `clk_out` toggle as above.
  - A valid config accepted here is stored in `pend_div` -> PENDING.
  - `enable`=0 with `clk_out`=0: next edge forces counter to 0 -> STOPPED.
  - `enable`=0 with `clk_out`=1: the block continues until the falling toggle, then goes to STOPPED in that same edge.
- **PENDING**
  - Counting continues with the old ratio.
  - At the next falling toggle (`clk_out` 1->0): `active_div`<=`pend_div`, counter 0, -> RUN (or STOPPED if `enable`=0).
  - If `clk_out`=0 on entry, the falling toggle is the one ending the next high phase; the current low phase completes at the old ratio.
- Handshake:
  - Transfer occurs when `cfg_valid & cfg_ready`.
  - `cfg_ready`=1 in STOPPED and RUN; 0 in PENDING.
  - Invalid ratio (bit0=1 or value<2) is consumed: `cfg_err` pulses the next cycle, state and `active_div` are unchanged.
- Simultaneous `enable` fall and config acceptance in RUN: both are honoured. The new ratio loads at the stop edge.
- Reset mid-operation immediately forces STOPPED and abandons any pending ratio.

## Timing
- Reset values:
  - `clk_out`=0, `tick_rise`=0, `tick_fall`=0, `cfg_err`=0, `busy`=0.
  - `cfg_ready`=1, `active_div`=DEFAULT_DIV, counter 0, state STOPPED.
- `enable` sampled high at edge k: RUN from k, `busy`=1 after k, `clk_out` rises after edge k+half.
- Period is exactly `active_div` cycles; high and low phases are each `half` cycles.
- `tick_rise`/`tick_fall` are registered together with the `clk_out` toggle, so they are aligned with its new value.
- Config latency in RUN: the new ratio takes effect on the first low phase after the next falling edge. The old ratio always completes the current high phase.
- In STOPPED, the ratio is loaded 1 cycle after the handshake.
- `cfg_err` appears 1 cycle after the rejected handshake and lasts 1 cycle.
- `busy` drops in the cycle after the stop edge.

## Test plan
- **Reset and default run:** DEFAULT_DIV=4, raise `enable` at edge k.
  - `clk_out` rises after k+2, period 4, duty 2/2.
  - Ticks coincide with the edges of `clk_out`.
- **Live retune:** running at div 4, send `cfg_div`=10 while `clk_out`=1.
  - `cfg_ready` is low until the falling edge.
  - The next low phase is 5 cycles and `active_div`=10.
  - There is no phase shorter than 2 cycles.
- **Invalid config:** send `cfg_div`=7, then `cfg_div`=0.
  - `cfg_err` pulses once for each.
  - `active_div` and the waveform are unchanged.
- **Clean stop:** div 8, drop `enable` two cycles into the high phase.
  - `clk_out` stays high 4 cycles total, then 0.
  - STOPPED is reached and `busy` is 0 one cycle later.
- **Simultaneous events:** in RUN, `enable` falls in the same cycle as a handshake with `cfg_div`=6.
  - The block stops at the falling edge with `active_div`=6.
  - Re-enable gives a period of 6.
- **Async reset in PENDING:** pulse `rstn` low mid-cycle.
  - Outputs go to reset values immediately.
  - `active_div`=DEFAULT_DIV and the pending ratio is discarded.
